score_keeper: RTL and testbench

- Score/serve controller for the two-player Pong game. Sits directly upstream of the per-player score digit renderers.
- Turns ball-out events into two 0–9 point counts and gates ball motion through a serve pause.
- Detects match end and latches the winner.
- point1/point2 feed the player 1 / player 2 digit renderers unchanged, 4-bit binary.

---
 rtl/score_keeper.sv | 135 +++++++++++++
 tb/tb_score_keeper.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Pong score/serve controller: turns ball-out events into two point counts,
// holds the ball through a serve pause and latches the match winner.
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       goal1,
  input  logic       goal2,
  output logic [3:0] point1,
  output logic [3:0] point2,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;

  localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
  localparam logic [7:0] PAUSE_VAL = 8'(PAUSE_FRAMES);

  state_t     state_reg, state_next;
  logic [3:0] point1_reg, point1_next;
  logic [3:0] point2_reg, point2_next;
  logic [7:0] pause_cnt_reg, pause_cnt_next;
  logic       serve_dir_reg, serve_dir_next;
  logic       winner_reg, winner_next;
  logic       ball_hold_reg, game_over_reg;
  logic       goal1_q, goal2_q;
  logic       score1_evt, score2_evt;

  assign score1_evt = goal1 & ~goal1_q;
  assign score2_evt = goal2 & ~goal2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      point1_reg    <= 4'd0;
      point2_reg    <= 4'd0;
      pause_cnt_reg <= 8'd0;
      serve_dir_reg <= 1'b0;
      winner_reg    <= 1'b0;
      ball_hold_reg <= 1'b1;
      game_over_reg <= 1'b0;
      goal1_q       <= 1'b0;
      goal2_q       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      point1_reg    <= point1_next;
      point2_reg    <= point2_next;
      pause_cnt_reg <= pause_cnt_next;
      serve_dir_reg <= serve_dir_next;
      winner_reg    <= winner_next;
      // Status flags follow the next state so they line up with it exactly.
      ball_hold_reg <= (state_next != PLAY);
      game_over_reg <= (state_next == OVER);
      goal1_q       <= goal1;
      goal2_q       <= goal2;
    end
  end

  always_comb begin
    state_next     = state_reg;
    point1_next    = point1_reg;
    point2_next    = point2_reg;
    pause_cnt_next = pause_cnt_reg;
    serve_dir_next = serve_dir_reg;
    winner_next    = winner_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = PLAY;
          point1_next = 4'd0;
          point2_next = 4'd0;
        end
      end
      PLAY: begin
        // goal1 wins a simultaneous rise; goal2's edge is simply lost.
        if (score1_evt) begin
          point1_next    = point1_reg + 4'd1;
          serve_dir_next = 1'b1;
          if (point1_reg + 4'd1 == WIN_VAL) begin
            state_next  = OVER;
            winner_next = 1'b0;
          end else begin
            state_next     = PAUSE;
            pause_cnt_next = 8'd0;
          end
        end else if (score2_evt) begin
          point2_next    = point2_reg + 4'd1;
          serve_dir_next = 1'b0;
          if (point2_reg + 4'd1 == WIN_VAL) begin
            state_next  = OVER;
            winner_next = 1'b1;
          end else begin
            state_next     = PAUSE;
            pause_cnt_next = 8'd0;
          end
        end
      end
      PAUSE: begin
        if (frame_tick) begin
          if (pause_cnt_reg + 8'd1 == PAUSE_VAL) begin
            state_next     = PLAY;
            pause_cnt_next = 8'd0;
          end else begin
            pause_cnt_next = pause_cnt_reg + 8'd1;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_next     = PLAY;
          point1_next    = 4'd0;
          point2_next    = 4'd0;
          serve_dir_next = ~winner_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign point1    = point1_reg;
  assign point2    = point2_reg;
  assign ball_hold = ball_hold_reg;
  assign serve_dir = serve_dir_reg;
  assign game_over = game_over_reg;
  assign winner    = winner_reg;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed match scenarios followed by random play,
// every cycle compared against a rule-level model of the match.
module tb_score_keeper;

  localparam int WIN = 3;
  localparam int PF  = 2;

  logic       clk = 1'b0;
  logic       reset, start, frame_tick, goal1, goal2;
  logic [3:0] point1, point2;
  logic       ball_hold, serve_dir, game_over, winner;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: match phase as plain integers (0 idle, 1 rally, 2 serve pause, 3 over).
  int m_phase = 0, m_p1 = 0, m_p2 = 0, m_wait = 0;
  int m_dir = 0, m_win = 0, m_last1 = 0, m_last2 = 0;

  score_keeper #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .goal1(goal1), .goal2(goal2), .point1(point1), .point2(point2),
    .ball_hold(ball_hold), .serve_dir(serve_dir), .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit t, input bit g1, input bit g2);
    bit new1, new2;
    if (r) begin
      m_phase = 0; m_p1 = 0; m_p2 = 0; m_wait = 0;
      m_dir = 0; m_win = 0; m_last1 = 0; m_last2 = 0;
      return;
    end
    new1 = g1 && !m_last1;
    new2 = g2 && !m_last2;
    case (m_phase)
      0: if (s) begin m_phase = 1; m_p1 = 0; m_p2 = 0; end
      1: begin
        if (new1) begin
          m_p1++; m_dir = 1;
          if (m_p1 == WIN) begin m_phase = 3; m_win = 0; end
          else begin m_phase = 2; m_wait = 0; end
        end else if (new2) begin
          m_p2++; m_dir = 0;
          if (m_p2 == WIN) begin m_phase = 3; m_win = 1; end
          else begin m_phase = 2; m_wait = 0; end
        end
      end
      2: if (t) begin
        m_wait++;
        if (m_wait == PF) begin m_phase = 1; m_wait = 0; end
      end
      default: if (s) begin m_phase = 1; m_p1 = 0; m_p2 = 0; m_dir = m_win ? 0 : 1; end
    endcase
    m_last1 = g1;
    m_last2 = g2;
  endtask

  task automatic step(input bit r, input bit s, input bit t, input bit g1, input bit g2,
                      input bit verbose);
    reset = r; start = s; frame_tick = t; goal1 = g1; goal2 = g2;
    @(posedge clk);
    cyc++;
    model_edge(r, s, t, g1, g2);
    #1;
    chk("point1", 32'(point1), 32'(m_p1));
    chk("point2", 32'(point2), 32'(m_p2));
    chk("ball_hold", 32'(ball_hold), 32'(m_phase != 1));
    chk("serve_dir", 32'(serve_dir), 32'(m_dir));
    chk("game_over", 32'(game_over), 32'(m_phase == 3));
    chk("winner", 32'(winner), 32'(m_win));
    if (verbose)
      $display("cyc=%0d in r=%0b s=%0b t=%0b g=%0b%0b -> p1=%0d p2=%0d hold=%0b dir=%0b over=%0b win=%0b",
               cyc, r, s, t, g1, g2, point1, point2, ball_hold, serve_dir, game_over, winner);
  endtask

  initial begin
    bit r, s, t, g1, g2;
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; goal1 = 1'b0; goal2 = 1'b0;

    // Reset state
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("rst_hold", 32'(ball_hold), 32'd1);
    chk("rst_over", 32'(game_over), 32'd0);
    step(0, 0, 0, 0, 0, 1);

    // Start releases the ball
    step(0, 1, 0, 0, 0, 1);
    chk("start_hold", 32'(ball_hold), 32'd0);
    chk("start_p1", 32'(point1), 32'd0);

    // goal1 held for 50 cycles scores exactly once, including across the pause
    step(0, 0, 0, 1, 0, 1);
    chk("g1_p1", 32'(point1), 32'd1);
    chk("g1_hold", 32'(ball_hold), 32'd1);
    chk("g1_dir", 32'(serve_dir), 32'd1);
    step(0, 0, 1, 1, 0, 1);
    step(0, 0, 1, 1, 0, 1);
    chk("release_hold", 32'(ball_hold), 32'd0);
    for (int i = 0; i < 47; i++) step(0, 0, 0, 1, 0, 1);
    chk("held_p1", 32'(point1), 32'd1);
    step(0, 0, 0, 0, 0, 1);

    // Simultaneous rise: only player 1 counts
    step(0, 0, 0, 1, 1, 1);
    chk("both_p1", 32'(point1), 32'd2);
    chk("both_p2", 32'(point2), 32'd0);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);

    // Player 2 wins with three separated goals
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 0, 1);
    end
    chk("end_over", 32'(game_over), 32'd1);
    chk("end_win", 32'(winner), 32'd1);
    chk("end_p2", 32'(point2), 32'd3);
    for (int i = 0; i < 6; i++) step(0, 0, i[0], i[1], ~i[1], 1);
    chk("frozen_p2", 32'(point2), 32'd3);
    step(0, 1, 0, 0, 0, 1);
    chk("restart_over", 32'(game_over), 32'd0);
    chk("restart_dir", 32'(serve_dir), 32'd0);
    chk("restart_p2", 32'(point2), 32'd0);

    // Reset mid-pause, then a fresh pause count after restart
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("midrst_p1", 32'(point1), 32'd0);
    chk("midrst_hold", 32'(ball_hold), 32'd1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    chk("fresh_hold", 32'(ball_hold), 32'd1);
    step(0, 0, 1, 0, 0, 1);
    chk("fresh_release", 32'(ball_hold), 32'd0);

    // Random play
    g1 = 0; g2 = 0;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 19) == 0);
      t  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) g1 = ~g1;
      if ($urandom_range(0, 5) == 0) g2 = ~g2;
      step(r, s, t, g1, g2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
